// File: rtl/sieve_sched_pkg.sv
// Shared definitions for the segmented prime-sieve scheduler: data widths,
// default search window and segment size, and the scheduler state encoding.
package sieve_sched_pkg;

    // Width of every number, base and counter value.
    localparam int RANGE_W = 14;

    // Width of the bit offset inside one engine segment.
    localparam int SEG_W = 10;

    // Default search window (inclusive on both ends) and segment length.
    localparam int DEF_START   = 100;
    localparam int DEF_LIMIT   = 10000;
    localparam int DEF_SEG_LEN = 1000;

    // Scheduler states, in the order a run normally walks through them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SIEVE = 3'd2,
        ADDR  = 3'd3,
        DATA  = 3'd4,
        EMIT  = 3'd5,
        NEXT  = 3'd6
    } state_e;

endpackage : sieve_sched_pkg

// File: rtl/sieve_sched.sv
// Segmented prime-sieve scheduler. Hands consecutive segments of the search
// window to an external sieve engine, walks each finished bitmap one bit at a
// time and streams every prime found out over a valid/ready interface.
module sieve_sched #(
    parameter int RANGE_W = sieve_sched_pkg::RANGE_W,
    parameter int SEG_LEN = sieve_sched_pkg::DEF_SEG_LEN,
    parameter int SEG_W   = sieve_sched_pkg::SEG_W,
    parameter int START   = sieve_sched_pkg::DEF_START,
    parameter int LIMIT   = sieve_sched_pkg::DEF_LIMIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               abort,
    output logic               eng_start,
    output logic [RANGE_W-1:0] eng_base,
    input  logic               eng_done,
    output logic [SEG_W-1:0]   eng_rd_addr,
    input  logic               eng_rd_data,
    output logic               prime_valid,
    input  logic               prime_ready,
    output logic [RANGE_W-1:0] prime_data,
    output logic [RANGE_W-1:0] prime_cnt,
    output logic               busy,
    output logic               done
);

    import sieve_sched_pkg::*;

    // The last segment may run past LIMIT, so base+SEG_LEN must never wrap,
    // and a segment offset must be able to reach SEG_LEN-1.
    if (LIMIT + SEG_LEN >= (2 ** RANGE_W)) begin : g_range_too_small
        $error("sieve_sched: LIMIT+SEG_LEN does not fit in RANGE_W bits");
    end
    if (SEG_LEN > (2 ** SEG_W) || SEG_LEN < 1) begin : g_seg_w_too_small
        $error("sieve_sched: SEG_LEN does not fit in SEG_W offset bits");
    end
    if (START > LIMIT) begin : g_empty_window
        $error("sieve_sched: START must not exceed LIMIT");
    end

    localparam logic [RANGE_W-1:0] START_V   = RANGE_W'(START);
    localparam logic [RANGE_W-1:0] LIMIT_V   = RANGE_W'(LIMIT);
    localparam logic [RANGE_W-1:0] SEG_LEN_V = RANGE_W'(SEG_LEN);
    localparam logic [SEG_W-1:0]   LAST_OFF  = SEG_W'(SEG_LEN - 1);

    state_e             state_q, state_d;
    logic [RANGE_W-1:0] base_q, base_d;
    logic [SEG_W-1:0]   offset_q, offset_d;
    logic [RANGE_W-1:0] pdata_q, pdata_d;
    logic [RANGE_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;

    // Number currently addressed: segment base plus bit offset, modulo 2^RANGE_W.
    logic [RANGE_W-1:0] cur_num;
    assign cur_num = base_q + RANGE_W'(offset_q);

    // State and datapath registers; rst wins over every other input.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            offset_q <= '0;
            pdata_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            offset_q <= offset_d;
            pdata_q  <= pdata_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-datapath logic; abort overrides the state choice last.
    always_comb begin
        // NOTE: every signal gets a hold/idle default before the case so no
        // path through the block leaves one unassigned (no latch inference).
        state_d  = state_q;
        base_d   = base_q;
        offset_d = offset_q;
        pdata_d  = pdata_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (run && !abort) begin
                    base_d   = START_V;
                    offset_d = '0;
                    cnt_d    = '0;
                    state_d  = LOAD;
                end
            end

            LOAD: begin
                state_d = SIEVE;
            end

            SIEVE: begin
                if (eng_done) begin
                    offset_d = '0;
                    state_d  = ADDR;
                end
            end

            ADDR: begin
                state_d = DATA;
            end

            DATA: begin
                if (eng_rd_data) begin
                    pdata_d = cur_num;
                    state_d = EMIT;
                end else begin
                    state_d = NEXT;
                end
            end

            EMIT: begin
                // A handshake in the same cycle as abort still counts.
                if (prime_ready) begin
                    cnt_d   = cnt_q + RANGE_W'(1);
                    state_d = NEXT;
                end
            end

            NEXT: begin
                // LIMIT is tested before the segment end so the last segment
                // is clipped and nothing past LIMIT is ever read.
                if (cur_num == LIMIT_V) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (offset_q == LAST_OFF) begin
                    base_d   = base_q + SEG_LEN_V;
                    offset_d = '0;
                    state_d  = LOAD;
                end else begin
                    offset_d = offset_q + SEG_W'(1);
                    state_d  = ADDR;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    // Outputs decoded from the registered state so they follow reset at once.
    assign eng_start   = (state_q == LOAD);
    assign prime_valid = (state_q == EMIT);
    assign busy        = (state_q != IDLE);
    assign eng_base    = base_q;
    assign eng_rd_addr = offset_q;
    assign prime_data  = pdata_q;
    assign prime_cnt   = cnt_q;
    assign done        = done_q;

endmodule : sieve_sched

// File: tb/tb_sieve_sched.sv
// Bench for sieve_sched. Two instances with a 50-number segment starting at
// 100: instance A ends at 199 and instance B at 149. Each is driven by a
// behavioural sieve engine with random latency; the expected primes come from
// a plain trial-division list of the window.
module tb_sieve_sched;

    import sieve_sched_pkg::*;

    localparam int RW    = 14;
    localparam int SW    = 10;
    localparam int SEG   = 50;
    localparam int ST    = 100;
    // 199 closes the second segment exactly, so a run takes two engine loads
    // (a limit of 200 would need a third, one-number segment at base 200).
    localparam int LIM_A = 199;
    localparam int LIM_B = 149;

    typedef struct {
        logic rst;
        logic run;
        logic abort;
        logic busy;
        logic es;
        logic pv;
        logic done;
        int   cnt;
        int   base;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst      = 1'b1;
    logic run_a    = 1'b0;
    logic abort_a  = 1'b0;
    logic ready_a  = 1'b1;
    logic inject_a = 1'b0;
    logic run_b    = 1'b0;
    logic abort_b  = 1'b0;
    logic ready_b  = 1'b1;

    int ref_a[$];
    int ref_b[$];

    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++)
            if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- instance A ----------------
    logic          es_a, pv_a, busy_a, done_a, eng_done_a;
    logic          rd_a = 1'b0;
    logic [RW-1:0] base_a, pd_a, pc_a;
    logic [SW-1:0] addr_a;

    sieve_sched #(.RANGE_W(RW), .SEG_LEN(SEG), .SEG_W(SW), .START(ST), .LIMIT(LIM_A)) u_dut_a (
        .clk(clk), .rst(rst), .run(run_a), .abort(abort_a),
        .eng_start(es_a), .eng_base(base_a), .eng_done(eng_done_a),
        .eng_rd_addr(addr_a), .eng_rd_data(rd_a),
        .prime_valid(pv_a), .prime_ready(ready_a), .prime_data(pd_a),
        .prime_cnt(pc_a), .busy(busy_a), .done(done_a)
    );

    logic m_done_a = 1'b0;
    logic e_act_a  = 1'b0;
    int   e_cnt_a  = 0;
    assign eng_done_a = m_done_a | inject_a;

    // Engine A: registered bitmap read, done pulse 3..7 cycles after a start.
    always @(posedge clk) begin
        m_done_a <= 1'b0;
        rd_a     <= is_prime(int'(base_a) + int'(addr_a));
        if (rst) begin
            e_act_a <= 1'b0;
        end else if (es_a) begin
            e_act_a <= 1'b1;
            e_cnt_a <= int'($urandom_range(2, 6));
        end else if (e_act_a) begin
            if (e_cnt_a == 0) begin
                m_done_a <= 1'b1;
                e_act_a  <= 1'b0;
            end else begin
                e_cnt_a <= e_cnt_a - 1;
            end
        end
    end

    int            acc_a[$];
    int            starts_a[$];
    int            dones_a   = 0;
    logic          hold_prev = 1'b0;
    logic [RW-1:0] pd_prev   = '0;

    // Monitor A: accepted primes, engine loads, done pulses, hold-while-stalled.
    always @(negedge clk) begin
        if (pv_a && ready_a) acc_a.push_back(int'(pd_a));
        if (es_a) starts_a.push_back(int'(base_a));
        if (done_a) dones_a++;
        if (hold_prev) begin
            check("valid_held", pv_a, 1);
            check("data_held", pd_a, pd_prev);
        end
        hold_prev = pv_a && !ready_a && !abort_a && !rst;
        pd_prev   = pd_a;
    end

    // ---------------- instance B ----------------
    logic          es_b, pv_b, busy_b, done_b, eng_done_b;
    logic          rd_b = 1'b0;
    logic [RW-1:0] base_b, pd_b, pc_b;
    logic [SW-1:0] addr_b;

    sieve_sched #(.RANGE_W(RW), .SEG_LEN(SEG), .SEG_W(SW), .START(ST), .LIMIT(LIM_B)) u_dut_b (
        .clk(clk), .rst(rst), .run(run_b), .abort(abort_b),
        .eng_start(es_b), .eng_base(base_b), .eng_done(eng_done_b),
        .eng_rd_addr(addr_b), .eng_rd_data(rd_b),
        .prime_valid(pv_b), .prime_ready(ready_b), .prime_data(pd_b),
        .prime_cnt(pc_b), .busy(busy_b), .done(done_b)
    );

    logic e_act_b = 1'b0;
    int   e_cnt_b = 0;
    logic m_done_b = 1'b0;
    assign eng_done_b = m_done_b;

    // Engine B: same behaviour as engine A, no injected pulses.
    always @(posedge clk) begin
        m_done_b <= 1'b0;
        rd_b     <= is_prime(int'(base_b) + int'(addr_b));
        if (rst) begin
            e_act_b <= 1'b0;
        end else if (es_b) begin
            e_act_b <= 1'b1;
            e_cnt_b <= int'($urandom_range(2, 6));
        end else if (e_act_b) begin
            if (e_cnt_b == 0) begin
                m_done_b <= 1'b1;
                e_act_b  <= 1'b0;
            end else begin
                e_cnt_b <= e_cnt_b - 1;
            end
        end
    end

    int acc_b[$];
    int starts_b = 0;
    int dones_b  = 0;
    int max_rd_b = 0;

    // Monitor B: accepted primes, load count and highest number addressed.
    always @(negedge clk) begin
        if (pv_b && ready_b) acc_b.push_back(int'(pd_b));
        if (es_b) starts_b++;
        if (done_b) dones_b++;
        if (busy_b && (int'(base_b) + int'(addr_b)) > max_rd_b)
            max_rd_b = int'(base_b) + int'(addr_b);
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        acc_a.delete();
        starts_a.delete();
        dones_a = 0;
    endtask

    task automatic check_list(input string name, input int got[$], input int exp[$]);
        check($sformatf("%s_len", name), got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s[%0d]", name, i), (i < got.size()) ? got[i] : -1, exp[i]);
    endtask

    task automatic pulse_run_a(input string name);
        run_a = 1'b1;
        tick();
        run_a = 1'b0;
        check({name, "_start_pulse"}, es_a, 1);
        check({name, "_start_base"}, base_a, ST);
        check({name, "_cnt_cleared"}, pc_a, 0);
    endtask

    task automatic wait_done_a(input string name, input int budget, input bit rnd);
        int n = 0;
        while (done_a !== 1'b1 && n < budget) begin
            if (rnd) ready_a = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check({name, "_done_in_budget"}, done_a, 1);
        ready_a = 1'b1;
    endtask

    task automatic run_full_a(input string name, input bit rnd);
        clear_a();
        pulse_run_a(name);
        wait_done_a(name, 3000, rnd);
        tick();
        check_list({name, "_primes"}, acc_a, ref_a);
        check({name, "_cnt"}, pc_a, ref_a.size());
        check({name, "_dones"}, dones_a, 1);
        check({name, "_loads"}, starts_a.size(), 2);
        check({name, "_load0"}, (starts_a.size() > 0) ? starts_a[0] : -1, ST);
        check({name, "_load1"}, (starts_a.size() > 1) ? starts_a[1] : -1, ST + SEG);
        check({name, "_idle"}, busy_a, 0);
    endtask

    // Global time limit so the run always ends on its own.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t vecs[10];
        bit   found;
        int   k;

        for (int v = ST; v <= LIM_A; v++) if (is_prime(v)) ref_a.push_back(v);
        for (int v = ST; v <= LIM_B; v++) if (is_prime(v)) ref_b.push_back(v);

        //            rst   run   abort  busy  es    pv    done  cnt base
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, ST};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, ST};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, ST};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, ST};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, ST};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, ST};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};

        tick();
        tick();

        // Reset, run, abort and run-while-busy, one clock per vector.
        for (int i = 0; i < 10; i++) begin
            rst     = vecs[i].rst;
            run_a   = vecs[i].run;
            abort_a = vecs[i].abort;
            tick();
            check($sformatf("vec%0d_busy", i), busy_a, vecs[i].busy);
            check($sformatf("vec%0d_eng_start", i), es_a, vecs[i].es);
            check($sformatf("vec%0d_valid", i), pv_a, vecs[i].pv);
            check($sformatf("vec%0d_done", i), done_a, vecs[i].done);
            check($sformatf("vec%0d_cnt", i), pc_a, vecs[i].cnt);
            check($sformatf("vec%0d_base", i), base_a, vecs[i].base);
        end
        rst = 1'b0; run_a = 1'b0; abort_a = 1'b0;
        tick();
        tick();

        // Full run with downstream always ready, then with random stalls.
        run_full_a("run_ready", 1'b0);
        run_full_a("run_stall", 1'b1);

        // Reset during SIEVE, engine done pulse one cycle after reset.
        clear_a();
        pulse_run_a("rst_sieve");
        tick();
        check("rst_sieve_in_sieve", busy_a, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        inject_a = 1'b1;
        tick();
        inject_a = 1'b0;
        check("rst_busy", busy_a, 0);
        check("rst_eng_start", es_a, 0);
        check("rst_valid", pv_a, 0);
        check("rst_done", done_a, 0);
        check("rst_cnt", pc_a, 0);
        check("rst_data", pd_a, 0);
        check("rst_base", base_a, 0);
        check("rst_addr", addr_a, 0);
        tick();
        tick();
        check("rst_done_ignored_busy", busy_a, 0);
        check("rst_done_ignored_start", starts_a.size(), 1);

        // Abort while 113 is stalled in EMIT.
        clear_a();
        ready_a = 1'b1;
        pulse_run_a("abort_emit");
        found = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            if (pv_a && pd_a == RW'(113)) found = 1'b1;
            else tick();
        end
        ready_a = 1'b0;
        check("abort_reach_113", found, 1);
        tick();
        check("abort_emit_valid", pv_a, 1);
        check("abort_emit_data", pd_a, 113);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        ready_a = 1'b1;
        check("abort_busy", busy_a, 0);
        check("abort_valid", pv_a, 0);
        check("abort_cnt", pc_a, 4);
        tick();
        tick();
        tick();
        check("abort_no_done", dones_a, 0);
        check("abort_cnt_kept", pc_a, 4);
        check("abort_accepted", acc_a.size(), 4);

        // A new run after the abort starts again from the first segment.
        run_full_a("after_abort", 1'b0);

        // run held high: the next run starts right after done.
        clear_a();
        run_a = 1'b1;
        tick();
        wait_done_a("held", 3000, 1'b0);
        check("held_idle_at_done", busy_a, 0);
        tick();
        check("held_restart_busy", busy_a, 1);
        check("held_restart_start", es_a, 1);
        check("held_restart_base", base_a, ST);
        check("held_restart_cnt", pc_a, 0);
        run_a   = 1'b0;
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check_list("held_primes", acc_a, ref_a);
        check("held_dones", dones_a, 1);
        tick();

        // Random stall patterns against the reference list.
        for (int r = 0; r < 4; r++) run_full_a($sformatf("rand%0d", r), 1'b1);

        // Random abort points: accepted primes form a prefix, count agrees.
        for (int r = 0; r < 3; r++) begin
            clear_a();
            pulse_run_a($sformatf("rabort%0d", r));
            k = int'($urandom_range(10, 250));
            for (int n = 0; n < k; n++) begin
                ready_a = 1'($urandom_range(0, 1));
                tick();
            end
            abort_a = 1'b1;
            tick();
            abort_a = 1'b0;
            ready_a = 1'b1;
            check($sformatf("rabort%0d_busy", r), busy_a, 0);
            check($sformatf("rabort%0d_valid", r), pv_a, 0);
            tick();
            tick();
            check($sformatf("rabort%0d_cnt", r), pc_a, acc_a.size());
            check($sformatf("rabort%0d_no_done", r), dones_a, 0);
            for (int i = 0; i < acc_a.size(); i++)
                check($sformatf("rabort%0d_prefix[%0d]", r, i), acc_a[i],
                      (i < ref_a.size()) ? ref_a[i] : -1);
        end

        // Instance B: limit falls on the last offset of the first segment.
        run_b = 1'b1;
        tick();
        run_b = 1'b0;
        begin
            int n = 0;
            while (done_b !== 1'b1 && n < 3000) begin
                tick();
                n++;
            end
        end
        check("clip_done_in_budget", done_b, 1);
        check("clip_last_offset", addr_b, SEG - 1);
        check("clip_last_base", base_b, ST);
        tick();
        check_list("clip_primes", acc_b, ref_b);
        check("clip_last_prime", (acc_b.size() > 0) ? acc_b[acc_b.size() - 1] : -1, LIM_B);
        check("clip_loads", starts_b, 1);
        check("clip_max_read_ok", (max_rd_b <= LIM_B) ? 1 : 0, 1);
        check("clip_cnt", pc_b, ref_b.size());
        check("clip_dones", dones_b, 1);
        check("clip_idle", busy_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_sieve_sched
